// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory with 1-cycle read latency.
// Port 0 has fixed priority; port 1 is guaranteed a slot after STARVE_LIMIT denied cycles.
module mem_arbiter #(
  parameter int AWIDTH       = 16,
  parameter int DWIDTH       = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int CWIDTH       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [AWIDTH-1:0] p0_addr_i,
  input  logic [DWIDTH-1:0] p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [DWIDTH-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [AWIDTH-1:0] p1_addr_i,
  input  logic [DWIDTH-1:0] p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [DWIDTH-1:0] p1_rdata_o,
  output logic [AWIDTH-1:0] mem_raddr_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic [AWIDTH-1:0] mem_waddr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o
);

  localparam logic [CWIDTH-1:0] LIMIT  = CWIDTH'(STARVE_LIMIT);
  localparam logic              OVR_EN = (STARVE_LIMIT != 0);

  logic [CWIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_port_q, rd_port_d;
  logic              p1_win;
  logic              any_gnt;
  logic              gnt_we;

  always_comb begin
    p1_win      = p1_req_i & (~p0_req_i | (OVR_EN & (starve_cnt_q == LIMIT)));
    p1_gnt_o    = ~reset & p1_win;
    p0_gnt_o    = ~reset & p0_req_i & ~p1_win;
    any_gnt     = p0_gnt_o | p1_gnt_o;

    // Port 0 values pass through whenever port 1 is not granted.
    gnt_we      = p1_gnt_o ? p1_we_i    : p0_we_i;
    mem_raddr_o = p1_gnt_o ? p1_addr_i  : p0_addr_i;
    mem_waddr_o = p1_gnt_o ? p1_addr_i  : p0_addr_i;
    mem_wdata_o = p1_gnt_o ? p1_wdata_i : p0_wdata_i;
    mem_wr_o    = any_gnt & gnt_we;
    mem_rd_o    = any_gnt & ~gnt_we;

    starve_cnt_d = starve_cnt_q;
    if (reset || p1_gnt_o || !p1_req_i) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CWIDTH'(1);
    end

    rd_pend_d   = mem_rd_o;
    rd_port_d   = p1_gnt_o;

    // Gating with reset drops a read that was in flight when reset arrived.
    p0_rvalid_o = ~reset & rd_pend_q & ~rd_port_q;
    p1_rvalid_o = ~reset & rd_pend_q &  rd_port_q;
    p0_rdata_o  = mem_rdata_i;
    p1_rdata_o  = mem_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_port_q    <= rd_port_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (override at 8 and disabled) share stimulus;
// each has its own memory and is compared against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;

  logic [1:0]       g0, g1, rv0, rv1, mrd, mwr;
  logic [1:0][15:0] rdat0, rdat1, raddr, waddr, wdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [15:0] dmem [64];
    logic [15:0] mq;

    always @(posedge clk) begin
      if (pl_en) dmem[pl_addr] <= pl_data;
      if (mwr[k]) dmem[waddr[k][5:0]] <= wdat[k];
      if (mrd[k]) mq <= dmem[raddr[k][5:0]];
    end

    mem_arbiter #(
      .AWIDTH(16), .DWIDTH(16), .STARVE_LIMIT(k == 0 ? 8 : 0), .CWIDTH(4)
    ) u_dut (
      .clk(clk), .reset(rst),
      .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
      .p0_gnt_o(g0[k]), .p0_rvalid_o(rv0[k]), .p0_rdata_o(rdat0[k]),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
      .p1_gnt_o(g1[k]), .p1_rvalid_o(rv1[k]), .p1_rdata_o(rdat1[k]),
      .mem_raddr_o(raddr[k]), .mem_rdata_i(mq), .mem_waddr_o(waddr[k]),
      .mem_wdata_o(wdat[k]), .mem_wr_o(mwr[k]), .mem_rd_o(mrd[k])
    );
  end

  // Reference model state, one slot per instance.
  int          lim    [2] = '{8, 0};
  int          denied [2];
  bit          pend   [2];
  bit          pport  [2];
  logic [15:0] pdata  [2];
  logic [15:0] ref_mem [2][64];
  bit          eg0 [2];
  bit          eg1 [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic settle();
    #1;
    for (int k = 0; k < 2; k++) begin
      bit e0, e1, ewe, erv0, erv1;
      e1 = !rst && p1_req && (!p0_req || (lim[k] != 0 && denied[k] >= lim[k]));
      e0 = !rst && p0_req && !e1;
      eg0[k] = e0;
      eg1[k] = e1;
      ewe = e1 ? p1_we : p0_we;
      chk($sformatf("i%0d_gnt0", k), g0[k], e0);
      chk($sformatf("i%0d_gnt1", k), g1[k], e1);
      chk($sformatf("i%0d_mem_rd", k), mrd[k], (e0 || e1) && !ewe);
      chk($sformatf("i%0d_mem_wr", k), mwr[k], (e0 || e1) && ewe);
      if ((e0 || e1) && !ewe)
        chk($sformatf("i%0d_raddr", k), raddr[k], e1 ? p1_addr : p0_addr);
      if ((e0 || e1) && ewe) begin
        chk($sformatf("i%0d_waddr", k), waddr[k], e1 ? p1_addr : p0_addr);
        chk($sformatf("i%0d_wdata", k), wdat[k], e1 ? p1_wdata : p0_wdata);
      end
      erv0 = !rst && pend[k] && !pport[k];
      erv1 = !rst && pend[k] && pport[k];
      chk($sformatf("i%0d_rvalid0", k), rv0[k], erv0);
      chk($sformatf("i%0d_rvalid1", k), rv1[k], erv1);
      if (erv0) chk($sformatf("i%0d_rdata0", k), rdat0[k], pdata[k]);
      if (erv1) chk($sformatf("i%0d_rdata1", k), rdat1[k], pdata[k]);
    end
  endtask

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      bit          gwe;
      logic [15:0] ga, gd;
      if (rst) begin
        denied[k] = 0;
        pend[k]   = 0;
      end else begin
        denied[k] = (eg1[k] || !p1_req) ? 0 : denied[k] + 1;
        gwe = eg1[k] ? p1_we : p0_we;
        ga  = eg1[k] ? p1_addr : p0_addr;
        gd  = eg1[k] ? p1_wdata : p0_wdata;
        pend[k]  = (eg0[k] || eg1[k]) && !gwe;
        pport[k] = eg1[k];
        pdata[k] = ref_mem[k][ga[5:0]];
        if ((eg0[k] || eg1[k]) && gwe) ref_mem[k][ga[5:0]] = gd;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic rnd_p0();
    p0_req   = ($urandom_range(0, 9) < 7);
    p0_we    = 1'($urandom_range(0, 1));
    p0_addr  = 16'($urandom_range(0, 63));
    p0_wdata = 16'($urandom);
  endtask

  task automatic rnd_p1();
    p1_req   = ($urandom_range(0, 9) < 5);
    p1_we    = 1'($urandom_range(0, 1));
    p1_addr  = 16'($urandom_range(0, 63));
    p1_wdata = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    pl_en = 0; pl_addr = 0; pl_data = 0;
    for (int k = 0; k < 2; k++) begin
      denied[k] = 0; pend[k] = 0; pport[k] = 0; pdata[k] = 0;
    end
    @(negedge clk);

    // Preload memory while reset is held.
    for (int i = 0; i < 64; i++) begin
      logic [15:0] d;
      d = (i == 16) ? 16'h1234 : (i == 32) ? 16'hBEEF : 16'(i * 257) ^ 16'h3C00;
      pl_en = 1; pl_addr = 6'(i); pl_data = d;
      ref_mem[0][i] = d;
      ref_mem[1][i] = d;
      @(posedge clk);
      @(negedge clk);
    end
    pl_en = 0;

    // Reset state with requests present.
    p0_req = 1; p1_req = 1; p1_we = 1;
    settle();
    chk("rst_gnt0", g0[0], 0);
    chk("rst_wr", mwr[0], 0);
    advance();
    rst = 0; p0_req = 0; p1_req = 0; p1_we = 0;
    cyc();

    // Single read, port 0.
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    settle();
    chk("p0rd_gnt", g0[0], 1);
    chk("p0rd_raddr", raddr[0], 16'h0010);
    advance();
    p0_req = 0;
    settle();
    chk("p0rd_rvalid", rv0[0], 1);
    chk("p0rd_rdata", rdat0[0], 16'h1234);
    advance();

    // Single read, port 1.
    p1_req = 1; p1_we = 0; p1_addr = 16'h0020;
    settle();
    chk("p1rd_gnt", g1[0], 1);
    advance();
    p1_req = 0;
    settle();
    chk("p1rd_rvalid", rv1[0], 1);
    chk("p1rd_rvalid0", rv0[0], 0);
    chk("p1rd_rdata", rdat1[0], 16'hBEEF);
    advance();

    // Contention: limit 8 gives port 1 every 9th slot; limit 0 never does.
    p0_req = 1; p0_we = 0; p0_addr = 16'h0001;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0002;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (c < 18) chk($sformatf("starve_c%0d", c), g1[0], (c % 9) == 8);
      chk($sformatf("noovr_c%0d", c), g1[1], 0);
      advance();
    end
    p0_req = 0;
    settle();
    chk("noovr_drop", g1[1], 1);
    advance();
    p1_req = 0;
    cyc();

    // Write from port 0 beats read from port 1 to the same address.
    p0_req = 1; p0_we = 1; p0_addr = 16'h0004; p0_wdata = 16'hA5A5;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0004;
    settle();
    chk("mix_wr", mwr[0], 1);
    chk("mix_g1", g1[0], 0);
    advance();
    p0_req = 0;
    settle();
    chk("mix_g1b", g1[0], 1);
    chk("mix_norv", rv0[0], 0);
    advance();
    p1_req = 0;
    settle();
    chk("mix_rdata", rdat1[0], 16'hA5A5);
    advance();

    // Alternating reads, no bubble.
    p0_req = 1; p0_we = 0; p0_addr = 16'h0005;
    cyc();
    p0_req = 0; p1_req = 1; p1_we = 0; p1_addr = 16'h0006;
    settle();
    chk("alt_rv0a", rv0[0], 1);
    advance();
    p1_req = 0; p0_req = 1; p0_addr = 16'h0007;
    settle();
    chk("alt_rv1", rv1[0], 1);
    advance();
    p0_req = 0;
    settle();
    chk("alt_rv0b", rv0[0], 1);
    advance();

    // Reset arriving right after a port 1 read grant.
    p1_req = 1; p1_we = 0; p1_addr = 16'h0009;
    settle();
    chk("rmid_g1", g1[0], 1);
    advance();
    rst = 1; p0_req = 1; p0_we = 1;
    settle();
    chk("rmid_rv1", rv1[0], 0);
    chk("rmid_rd", mrd[0], 0);
    advance();
    cyc();
    rst = 0; p1_req = 0; p0_we = 0; p0_addr = 16'h000A;
    settle();
    chk("rmid_resume", g0[0], 1);
    advance();
    p0_req = 0;

    // Randomized traffic; requests are held until the limit-8 instance grants them.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      cyc();
      if (!p0_req || eg0[0]) rnd_p0();
      if (!p1_req || eg1[0]) rnd_p1();
    end
    rst = 0; p0_req = 0; p1_req = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous memory port between two requesters. Port 0 is high priority (CPU data/instruction traffic). Port 1 is low priority (DMA/debug).
- Sits between the requesters and the memory's raddr/rdata/waddr/wdata/wr/rd interface, which has a fixed 1-cycle read latency.
- Arbitration is fixed priority to port 0, with a starvation override that guarantees port 1 forward progress.
- Tracks each outstanding read so read data is returned, with a valid strobe, to the port that issued it.

Parameters:
- AWIDTH, 16, address width.
- DWIDTH, 16, data width.
- STARVE_LIMIT, 8: consecutive cycles port 1 may be denied before it wins one arbitration. 0 disables the override (pure fixed priority).
- CWIDTH, 4: starvation counter width. Must satisfy STARVE_LIMIT < 2^CWIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req_i  in  1  port 0 request.
- p0_we_i  in  1  port 0 write (1) / read (0).
- p0_addr_i  in  AWIDTH  port 0 address.
- p0_wdata_i  in  DWIDTH  port 0 write data.
- p0_gnt_o  out  1  port 0 access accepted this cycle.
- p0_rvalid_o  out  1  port 0 read data valid.
- p0_rdata_o  out  DWIDTH  port 0 read data.
- p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o: same as port 0, for port 1.
- mem_raddr_o  out  AWIDTH  memory read address.
- mem_rdata_i  in  DWIDTH  memory read data, valid the cycle after mem_rd_o.
- mem_waddr_o  out  AWIDTH  memory write address.
- mem_wdata_o  out  DWIDTH  memory write data.
- mem_wr_o  out  1  memory write strobe.
- mem_rd_o  out  1  memory read strobe.

Behaviour:
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - gnt is combinational from req in the same cycle. The access is performed in the cycle gnt=1.
  - At most one gnt is high per cycle.
- Arbitration:
  - By default, p0_req_i wins.
  - Port 1 wins when p1_req_i is high and either p0_req_i is low, or STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT.
- Starvation counter (starve_cnt, CWIDTH bits):
  - Cleared when p1_gnt_o=1 or p1_req_i=0.
  - Otherwise increments when p1_req_i=1 and p1_gnt_o=0, saturating at STARVE_LIMIT.
- Memory drive:
  - mem_raddr_o, mem_waddr_o and mem_wdata_o are muxed from the granted port. With no grant they carry port 0's values.
  - mem_wr_o = gnt & we. mem_rd_o = gnt & ~we.
  - Port 0's address, data and we are don't-care when no grant is issued.
- Read return pipeline:
  - Registers rd_pend and rd_port, set on the cycle of mem_rd_o.
  - The next cycle, pN_rvalid_o = rd_pend & (rd_port==N).
  - Both pN_rdata_o are driven combinationally from mem_rdata_i. Their contents are meaningful only while the matching rvalid is high.
  - Read latency from gnt to rvalid is exactly 1 cycle.
  - Back-to-back reads, including alternating ports, sustain 1 per cycle.
- Writes produce no rvalid.
- Simultaneous read by one port and rvalid to the other in the same cycle is legal and independent.
- Reset (synchronous, active-high):
  - While reset=1: p0_gnt_o=p1_gnt_o=0, mem_wr_o=mem_rd_o=0, p0_rvalid_o=p1_rvalid_o=0.
  - At the edge: starve_cnt=0, rd_pend=0, rd_port=0.
  - A read granted in the cycle before reset asserts does not produce rvalid in the reset cycle.
  - The first grant is possible in the first cycle after reset deasserts.

Test Plan:
- Single reads:
  - Port 0 reads 0x0010 (memory holds 0x1234): p0_gnt_o=1 in cycle T with mem_rd_o=1 and mem_raddr_o=0x0010; at T+1, p0_rvalid_o=1 and p0_rdata_o=0x1234.
  - Repeat on port 1 for 0x0020/0xBEEF; p0_rvalid_o stays 0.
- Contention with STARVE_LIMIT=8: both ports hold read requests continuously.
  - Port 0 is granted 8 consecutive cycles, then port 1 gets exactly 1 grant in cycle 9 and the counter clears.
  - Pattern repeats every 9 cycles.
- Override disabled: STARVE_LIMIT=0 with both ports requesting for 20 cycles gives port 1 no grant; dropping p0_req_i grants port 1 the same cycle.
- Mixed traffic:
  - Port 0 writes 0xA5A5 to 0x0004 while port 1 requests a read of 0x0004: the write goes first (mem_wr_o=1, no rvalid).
  - Port 1's read is granted the next cycle and returns 0xA5A5 one cycle later.
- Alternating reads P0, P1, P0 on consecutive cycles (port 1 alone in the middle cycle): rvalids arrive on p0, p1, p0 in consecutive cycles with correct data and no bubble.
- Reset mid-operation:
  - Port 1 read granted in cycle T, reset asserted at T+1: no rvalid at T+1, starve_cnt=0.
  - During reset, requests get no grant and mem_wr_o=mem_rd_o=0.
  - Grants resume in the first cycle after reset deasserts.
